// File: rtl/axis_splitter_2_pkg.sv
// Shared AXIS lane definitions: lane depth, occupancy type and lane states.
package axis_splitter_2_pkg;

   localparam int SPLITTER_DEPTH = 2;

   typedef logic [1:0] lane_count_t;

   // Encoding equals the lane occupancy count.
   typedef enum logic [1:0] {
      LANE_EMPTY = 2'd0,
      LANE_HALF  = 2'd1,
      LANE_FULL  = 2'd2
   } lane_state_e;

endpackage

// File: rtl/axis_lane_fifo_2.sv
// Two-entry lane FIFO with registered full flag; one instance per splitter output lane.
//
// state      | meaning
// LANE_EMPTY | no buffered beat, out_valid low
// LANE_HALF  | one buffered beat
// LANE_FULL  | two buffered beats, writes blocked
module axis_lane_fifo_2
   import axis_splitter_2_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
);

   logic [DATA_WIDTH-1:0] mem [SPLITTER_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;
   lane_state_e           state;
   lane_state_e           state_next;
   lane_count_t           count;
   logic                  rd_en;
   logic                  full_q;

   assign count     = lane_count_t'(state);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign rd_en     = out_valid & out_ready;
   assign full      = full_q;

   always_comb begin
      state_next = state;
      case (state)
         LANE_EMPTY: if (wr_en) state_next = LANE_HALF;
         LANE_HALF: begin
            if (wr_en && !rd_en)      state_next = LANE_FULL;
            else if (rd_en && !wr_en) state_next = LANE_EMPTY;
         end
         LANE_FULL: if (rd_en) state_next = LANE_HALF;
         default:   state_next = LANE_EMPTY;
      endcase
   end

   // full_q resets high so the shared input_ready stays low until the first clock after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= LANE_EMPTY;
         full_q <= 1'b1;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         state  <= state_next;
         full_q <= (lane_count_t'(state_next) == lane_count_t'(SPLITTER_DEPTH));
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '{default: '0};
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/axis_splitter_2.sv
// Splits one joined beat into two independently drained AXIS lanes.
module axis_splitter_2
   import axis_splitter_2_pkg::*;
#(
   parameter int DATA_WIDTH_0 = 16,
   parameter int DATA_WIDTH_1 = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    input_valid,
   input  logic [DATA_WIDTH_0-1:0] input_data_0,
   input  logic [DATA_WIDTH_1-1:0] input_data_1,
   output logic                    input_ready,
   output logic                    output_0_valid,
   output logic [DATA_WIDTH_0-1:0] output_0_data,
   input  logic                    output_0_ready,
   output logic                    output_1_valid,
   output logic [DATA_WIDTH_1-1:0] output_1_data,
   input  logic                    output_1_ready
);

   logic full_0;
   logic full_1;
   logic wr_en;

   // Both full flags are registers, so input_ready never sees output_x_ready combinationally.
   assign input_ready = ~full_0 & ~full_1;
   assign wr_en       = input_valid & input_ready;

   axis_lane_fifo_2 #(.DATA_WIDTH(DATA_WIDTH_0)) u_lane_0 (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (input_data_0),
      .full      (full_0),
      .out_valid (output_0_valid),
      .out_data  (output_0_data),
      .out_ready (output_0_ready)
   );

   axis_lane_fifo_2 #(.DATA_WIDTH(DATA_WIDTH_1)) u_lane_1 (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (input_data_1),
      .full      (full_1),
      .out_valid (output_1_valid),
      .out_data  (output_1_data),
      .out_ready (output_1_ready)
   );

endmodule

// File: doc/axis_splitter_2.md
AXIS_SPLITTER_2 -- requirements
Module: axis_splitter_2

Interface
REQ-001 SHALL have parameter DATA_WIDTH_0, default 16: width of lane 0 payload.
REQ-002 SHALL have parameter DATA_WIDTH_1, default 16: width of lane 1 payload.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst as elsewhere in the codebase, with rst low = reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 input_valid  input  1  joined beat present.
REQ-007 input_data_0  input  DATA_WIDTH_0  payload destined for output 0.
REQ-008 input_data_1  input  DATA_WIDTH_1  payload destined for output 1.
REQ-009 input_ready  output  1  splitter accepts joined beat.
REQ-010 output_0_valid / output_0_data (DATA_WIDTH_0) outputs, output_0_ready input: independent AXIS lane 0.
REQ-011 output_1_valid / output_1_data (DATA_WIDTH_1) outputs, output_1_ready input: independent AXIS lane 1.

Function
REQ-012 SHALL implement the inverse of axis_synchronizer_2: one joined beat fans out as one beat on each output lane, lanes drained independently.
REQ-013 Each lane SHALL hold a 2-entry FIFO with occupancy counter 0..2; lane states EMPTY (0), HALF (1), FULL (2).
REQ-014 input_ready SHALL equal (count_0 != 2) AND (count_1 != 2), driven from registers only; no combinational path from output_x_ready to input_ready.
REQ-015 Input transfer (input_valid AND input_ready) SHALL write data_0 into lane 0 and data_1 into lane 1 in the same cycle; never one lane without the other.
REQ-016 output_x_valid SHALL be 1 iff count_x != 0; output_x_data SHALL be the oldest lane-x entry, registered.
REQ-017 Latency input transfer -> output_x_valid SHALL be exactly 1 cycle when lane x was EMPTY.
REQ-018 Lane transitions: write only -> count+1; read only (valid AND ready) -> count-1; simultaneous write and read -> count unchanged, data order preserved.
REQ-019 Simultaneous write and read in FULL SHALL not occur (input_ready low); in EMPTY a read SHALL not occur (valid low).
REQ-020 With both lanes continuously ready, throughput SHALL be 1 joined beat per cycle.
REQ-021 A stalled lane SHALL not block the other lane until the stalled lane reaches FULL; then input_ready drops for both.
REQ-022 Once asserted, output_x_valid SHALL stay high and output_x_data stable until output_x_ready is sampled high (AXIS rule).
REQ-023 Read/write pointers SHALL be 1 bit each and wrap 1 -> 0.
REQ-024 Module SHALL behave correctly with input_valid toggling arbitrarily; a beat not accepted SHALL not be written.

Reset
REQ-025 On rst low, asynchronously: count_0 = count_1 = 0, all pointers = 0, output_0_valid = output_1_valid = 0, input_ready = 0.
REQ-026 input_ready SHALL rise in the first cycle after rst deasserts (both lanes EMPTY).
REQ-027 Reset mid-operation SHALL discard all buffered beats; output_x_data value during reset is don't-care, registers may be zeroed.

Structure
REQ-028 Lane depth constant (SPLITTER_DEPTH = 2) and the occupancy count type SHALL live in the shared AXIS package.
REQ-029 One sub-module axis_lane_fifo_2 (parameter DATA_WIDTH; ports clk, rst, write strobe, write data, full, output valid/data/ready) SHALL be instantiated twice.
REQ-030 Top level SHALL contain only the input_ready AND and the shared write strobe.

Verification
REQ-031 Reset release, both drains ready, generator sends 0x0001..0x0005 on both lanes -> both outputs emit 0x0001..0x0005, one per cycle, first 1 cycle after acceptance.
REQ-032 output_0_ready held 0, output_1_ready 1, 4 beats offered -> exactly 2 accepted, lane 1 emits 2 beats, input_ready low from third offer; releasing output_0_ready yields both buffered beats in order.
REQ-033 Both lanes ready toggling in opposite phase for 20 cycles, sequential data -> each lane emits the identical ordered sequence, no loss, no duplication.
REQ-034 Lane 0 FULL with output_0_ready rising in same cycle as input_valid -> no write that cycle (input_ready registered low), write accepted next cycle.
REQ-035 rst pulsed low for 1 cycle with both lanes HALF -> valids drop immediately, next beat 0x00AA after release appears alone on both outputs.
REQ-036 Mixed widths DATA_WIDTH_0 = 8, DATA_WIDTH_1 = 24, inputs 0xA5 / 0x123456 -> outputs 0xA5 / 0x123456 unmodified.
